// File: rtl/tx_gearbox_sequencer.sv
//==============================================================================
// tx_gearbox_sequencer : 64b/66b TX scheduler with gearbox sequence counter,
//                        half-block handshake and idle block insertion.
// Optional statistics counters: define TX_GBSEQ_STATS_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tx_gearbox_sequencer #(
  parameter int         PIPE_LAT  = 2,
  parameter logic [7:0] IDLE_TYPE = 8'h1E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] blk_data_i,
  input  logic [1:0]  blk_head_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  output logic [31:0] data_o,
  output logic [1:0]  head_o,
  output logic [6:0]  seq_o,
  output logic [6:0]  gb_seq_o,
  output logic        running_o,
  output logic        idle_ins_o,
  output logic        underrun_o,
  output logic [31:0] idle_cnt_o,
  output logic [31:0] underrun_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [6:0] SEQ_PAUSE = 7'd32;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        isdata_q, isdata_d;
  logic [1:0]  hdr_q, hdr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  head_q, head_d;
  logic [6:0]  seq_q, seq_d;
  logic        idle_q, idle_d;
  logic        und_q, und_d;

  logic        active_w;
  logic        even_w;
  logic        pause_w;
  logic        boundary_w;
  logic [6:0]  cnt_inc_w;

  assign active_w   = (state_q == ST_RUN) || (state_q == ST_STOP);
  assign even_w     = ~cnt_q[0];
  assign pause_w    = (cnt_q == SEQ_PAUSE);
  // A stop request takes effect only where a new block would begin.
  assign boundary_w = (state_q == ST_STOP) && even_w && !pause_w;
  assign cnt_inc_w  = pause_w ? 7'd0 : cnt_q + 7'd1;

  assign blk_ready_o = active_w && !boundary_w && !pause_w && (even_w || isdata_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    isdata_d = isdata_q;
    hdr_d    = hdr_q;
    data_d   = data_q;
    head_d   = head_q;
    seq_d    = seq_q;
    idle_d   = 1'b0;
    und_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = 7'd0;
        data_d = '0;
        head_d = '0;
        seq_d  = '0;
        if (enable_i) state_d = ST_START;
      end
      ST_START: begin
        cnt_d   = 7'd0;
        data_d  = '0;
        head_d  = '0;
        seq_d   = '0;
        state_d = ST_RUN;
      end
      default: begin
        if (boundary_w) begin
          state_d = ST_IDLE;
          cnt_d   = 7'd0;
          data_d  = '0;
          head_d  = '0;
          seq_d   = '0;
        end else begin
          state_d = enable_i ? ST_RUN : ST_STOP;
          cnt_d   = cnt_inc_w;
          seq_d   = cnt_q;
          if (pause_w) begin
            // Gearbox pause slot: outputs hold, nothing is consumed.
          end else if (even_w) begin
            if (blk_valid_i) begin
              data_d   = blk_data_i;
              head_d   = blk_head_i;
              hdr_d    = blk_head_i;
              isdata_d = 1'b1;
            end else begin
              data_d   = {24'h0, IDLE_TYPE};
              head_d   = 2'b10;
              hdr_d    = 2'b10;
              isdata_d = 1'b0;
              idle_d   = 1'b1;
            end
          end else begin
            head_d = hdr_q;
            if (isdata_q && blk_valid_i) begin
              data_d = blk_data_i;
            end else begin
              data_d = '0;
              und_d  = isdata_q;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      isdata_q <= 1'b0;
      hdr_q    <= '0;
      data_q   <= '0;
      head_q   <= '0;
      seq_q    <= '0;
      idle_q   <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      isdata_q <= isdata_d;
      hdr_q    <= hdr_d;
      data_q   <= data_d;
      head_q   <= head_d;
      seq_q    <= seq_d;
      idle_q   <= idle_d;
      und_q    <= und_d;
    end
  end

  assign data_o     = data_q;
  assign head_o     = head_q;
  assign seq_o      = seq_q;
  assign idle_ins_o = idle_q;
  assign underrun_o = und_q;
  assign running_o  = (state_q == ST_RUN);

  // Sequence delay matching the scrambler pipeline in front of the gearbox.
  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign gb_seq_o = seq_q;
    end else begin : g_dly
      logic [6:0] dly_q [PIPE_LAT];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < PIPE_LAT; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= seq_q;
          for (int i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign gb_seq_o = dly_q[PIPE_LAT-1];
    end
  endgenerate

`ifdef TX_GBSEQ_STATS_EN
  logic [31:0] idle_cnt_q;
  logic [31:0] und_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt_q <= '0;
      und_cnt_q  <= '0;
    end else begin
      if (idle_q && (idle_cnt_q != 32'hFFFF_FFFF)) idle_cnt_q <= idle_cnt_q + 32'd1;
      if (und_q && (und_cnt_q != 32'hFFFF_FFFF))   und_cnt_q  <= und_cnt_q + 32'd1;
    end
  end

  assign idle_cnt_o     = idle_cnt_q;
  assign underrun_cnt_o = und_cnt_q;
`else
  assign idle_cnt_o     = '0;
  assign underrun_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_gearbox_sequencer.sv
//==============================================================================
// tb_tx_gearbox_sequencer : directed scoreboard bench for tx_gearbox_sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_tx_gearbox_sequencer;

  localparam int LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [31:0] blk_data_i;
  logic [1:0]  blk_head_i;
  logic        blk_valid_i;
  logic        blk_ready_o;
  logic [31:0] data_o;
  logic [1:0]  head_o;
  logic [6:0]  seq_o;
  logic [6:0]  gb_seq_o;
  logic        running_o;
  logic        idle_ins_o;
  logic        underrun_o;
  logic [31:0] idle_cnt_o;
  logic [31:0] underrun_cnt_o;

  tx_gearbox_sequencer #(.PIPE_LAT(LAT), .IDLE_TYPE(8'h1E)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .blk_data_i     (blk_data_i),
    .blk_head_i     (blk_head_i),
    .blk_valid_i    (blk_valid_i),
    .blk_ready_o    (blk_ready_o),
    .data_o         (data_o),
    .head_o         (head_o),
    .seq_o          (seq_o),
    .gb_seq_o       (gb_seq_o),
    .running_o      (running_o),
    .idle_ins_o     (idle_ins_o),
    .underrun_o     (underrun_o),
    .idle_cnt_o     (idle_cnt_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  head;
    logic [6:0]  seq;
    logic        idle;
    logic        und;
    logic        run;
  } exp_t;

  exp_t sb[$];
  logic [6:0] hist[$];

  int errors = 0;
  int checks = 0;
  int obs_idle = 0;
  int obs_und = 0;

  // Reference model state: 0 idle, 1 start, 2 run, 3 stop
  int          m_st;
  logic [6:0]  m_cnt;
  logic        m_isdata;
  logic [1:0]  m_hdr;
  logic [31:0] m_data;
  logic [1:0]  m_head;
  logic [31:0] m_icnt;
  logic [31:0] m_ucnt;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endfunction

  function automatic void model_reset();
    m_st = 0; m_cnt = 0; m_isdata = 0; m_hdr = 0;
    m_data = 0; m_head = 0; m_icnt = 0; m_ucnt = 0;
    hist.delete();
    for (int i = 0; i <= LAT; i++) hist.push_back(7'd0);
  endfunction

  task automatic cycle(input logic en, input logic v, input logic [31:0] d,
                       input logic [1:0] h, input logic r);
    exp_t e;
    logic act, even, pause, bnd, rdy;
    logic [6:0] gexp;
    @(negedge clk_i);
    rst_i = r; enable_i = en; blk_valid_i = v; blk_data_i = d; blk_head_i = h;
    act   = (m_st == 2) || (m_st == 3);
    even  = !m_cnt[0];
    pause = (m_cnt == 7'd32);
    bnd   = (m_st == 3) && even && !pause;
    rdy   = act && !bnd && !pause && (even || m_isdata);
    #1 chk("ready", {31'h0, blk_ready_o}, {31'h0, rdy});

    e = '0;
    if (r) begin
      model_reset();
    end else if (!act || bnd) begin
      e.data = 0; e.head = 0; e.seq = 0;
      if (m_st == 0) m_st = en ? 1 : 0;
      else if (m_st == 1) m_st = 2;
      else m_st = 0;
      m_cnt = 0;
    end else begin
      e.seq = m_cnt;
      e.data = m_data; e.head = m_head;
      if (pause) begin
        // hold
      end else if (even) begin
        if (v) begin
          e.data = d; e.head = h; m_hdr = h; m_isdata = 1;
        end else begin
          e.data = 32'h0000_001E; e.head = 2'b10; m_hdr = 2'b10; m_isdata = 0; e.idle = 1;
        end
      end else begin
        e.head = m_hdr;
        if (m_isdata && v) e.data = d;
        else begin
          e.data = 0;
          e.und = m_isdata;
        end
      end
      m_st  = en ? 2 : 3;
      m_cnt = pause ? 7'd0 : m_cnt + 7'd1;
    end
    e.run = (m_st == 2);
    m_data = e.data; m_head = e.head;
    sb.push_back(e);

    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    hist.push_back(e.seq);
    if (hist.size() > LAT + 1) void'(hist.pop_front());
    gexp = hist[0];
    chk("data_o", data_o, e.data);
    chk("head_o", {30'h0, head_o}, {30'h0, e.head});
    chk("seq_o", {25'h0, seq_o}, {25'h0, e.seq});
    chk("gb_seq_o", {25'h0, gb_seq_o}, {25'h0, gexp});
    chk("idle_ins_o", {31'h0, idle_ins_o}, {31'h0, e.idle});
    chk("underrun_o", {31'h0, underrun_o}, {31'h0, e.und});
    chk("running_o", {31'h0, running_o}, {31'h0, e.run});
`ifdef TX_GBSEQ_STATS_EN
    chk("idle_cnt_o", idle_cnt_o, m_icnt);
    chk("underrun_cnt_o", underrun_cnt_o, m_ucnt);
`else
    chk("idle_cnt_o", idle_cnt_o, 32'h0);
    chk("underrun_cnt_o", underrun_cnt_o, 32'h0);
`endif
    if (e.idle && m_icnt != 32'hFFFF_FFFF) m_icnt = m_icnt + 1;
    if (e.und && m_ucnt != 32'hFFFF_FFFF) m_ucnt = m_ucnt + 1;
    obs_idle += int'(idle_ins_o);
    obs_und  += int'(underrun_o);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, data_o, 32'h0);
    chk({tag, "_seq"}, {25'h0, seq_o}, 32'h0);
    chk({tag, "_gbseq"}, {25'h0, gb_seq_o}, 32'h0);
    chk({tag, "_ctl"}, {26'h0, head_o, running_o, idle_ins_o, underrun_o, blk_ready_o}, 32'h0);
    chk({tag, "_cnts"}, idle_cnt_o | underrun_cnt_o, 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] dv;
    rst_i = 1'b1; enable_i = 1'b0; blk_valid_i = 1'b0; blk_data_i = '0; blk_head_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 check_all_zero("reset");

    // Continuous data, crosses the pause slot twice
    dv = 32'h1000_0000;
    for (int i = 0; i < 75; i++) begin
      cycle(1'b1, 1'b1, dv, 2'b01, 1'b0);
      dv = dv + 1;
    end

    // No data: idle insertion every block
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 2'b01, 1'b0);
    obs_idle = 0;
    for (int i = 0; i < 33; i++) cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 2'b01, 1'b0);
    chk("idle_per_period", obs_idle, 16);

    // Valid drops only in the second half at seq 5
    obs_und = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, (m_cnt != 7'd5), dv, 2'b01, 1'b0);
      dv = dv + 1;
    end
    chk("underrun_once", obs_und, 1);

    // Stop requested while counter sits at 7
    n = 0;
    while (m_cnt != 7'd7 && n < 40) begin
      cycle(1'b1, 1'b1, dv, 2'b01, 1'b0);
      dv = dv + 1; n++;
    end
    cycle(1'b0, 1'b1, 32'hCAFE_0007, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, dv, 2'b01, 1'b0);
    chk("stopped_seq", {25'h0, seq_o}, 32'h0);
    chk("stopped_ready", {31'h0, blk_ready_o}, 32'h0);

    // Restart, brief stop request withdrawn mid-block
    n = 0;
    while (m_cnt != 7'd4 && n < 40) begin
      cycle(1'b1, 1'b1, dv, 2'b01, 1'b0);
      dv = dv + 1; n++;
    end
    cycle(1'b0, 1'b1, dv, 2'b01, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, dv, 2'b01, 1'b0);
      dv = dv + 1;
    end
    chk("resumed_running", {31'h0, running_o}, 32'h1);

    // Idle statistics then reset mid-block
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    n = 0;
    while (m_icnt < 100 && n < 400) begin
      cycle(1'b1, 1'b0, 32'h0, 2'b01, 1'b0);
      n++;
    end
    cycle(1'b1, 1'b1, 32'h0, 2'b01, 1'b0);
`ifdef TX_GBSEQ_STATS_EN
    chk("idle_cnt_100", idle_cnt_o, 32'd100);
`else
    chk("idle_cnt_tied", idle_cnt_o, 32'd0);
`endif
    n = 0;
    while (!m_cnt[0] && n < 4) begin
      cycle(1'b1, 1'b1, 32'h0, 2'b01, 1'b0);
      n++;
    end
    cycle(1'b1, 1'b1, 32'h0, 2'b01, 1'b1);
    check_all_zero("midblk_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tx_gearbox_sequencer.md
Name: tx_gearbox_sequencer

Overview:
- Schedules the TX 64b/66b path ahead of the scrambler and the 66b->64b gearbox.
- Owns the 7-bit gearbox sequence counter (0..32, pause at 32).
- Throttles the upstream encoder with a half-block ready/valid handshake.
- Inserts idle control blocks whenever no encoded block is available at a block boundary.
- Emits a delayed copy of the sequence so the gearbox sees a sequence aligned with its input after scrambler latency.

Parameters:
PIPE_LAT, 2, cycles between data_o and gearbox input (scrambler pipeline depth); range 0..7.
IDLE_TYPE, 8'h1E, block type byte placed in bits[7:0] of the first half of an inserted idle block.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  run request; level-sensitive
blk_data_i  in  32  half-block payload from encoder
blk_head_i  in  2  sync header; sampled on first half (even seq) only
blk_valid_i  in  1  upstream half-block valid
blk_ready_o  out  1  sequencer accepts half-block this cycle
data_o  out  32  half-block to scrambler
head_o  out  2  header accompanying data_o
seq_o  out  7  sequence aligned with data_o
gb_seq_o  out  7  seq_o delayed PIPE_LAT cycles; drives gearbox sequence_i
running_o  out  1  state is RUN
idle_ins_o  out  1  one-cycle pulse on first half of each inserted idle block
underrun_o  out  1  one-cycle pulse on a mid-block underrun
idle_cnt_o  out  32  inserted idle block count (optional feature)
underrun_cnt_o  out  32  underrun count (optional feature)

Behaviour:
- Reset: state IDLE; seq counter 0; all outputs 0; gb_seq_o delay line cleared to 0.
- States:
  - IDLE: ready=0, data_o/head_o=0, seq held 0. enable_i=1 -> START.
  - START: one cycle; counter forced to 0 -> RUN.
  - RUN: counter +1 per cycle, 32 wraps to 0. enable_i=0 -> STOP.
  - STOP: behaves as RUN until the next even seq that begins a block (0..30) -> IDLE, so the final block is always completed. enable_i re-asserted in STOP -> back to RUN without a counter break.
- Seq 32 (pause): ready=0; data_o/head_o hold their previous value; seq_o=32.
- Even seq 0..30, first half:
  - valid=1: accept (ready=1); data_o=blk_data_i, head_o=blk_head_i; block marked DATA.
  - valid=0: block marked IDLE; data_o={24'h0,IDLE_TYPE}, head_o=2'b10; idle_ins_o pulses.
- Odd seq, second half:
  - DATA block: ready=1. valid=1 -> data_o=blk_data_i. valid=0 -> data_o=0, underrun_o pulses; block still closes at next even seq.
  - IDLE block: ready=0; data_o=0.
- head_o on odd seq repeats the block's header.
- Latency: data_o/head_o/seq_o/pulses are registered exactly 1 cycle after the handshake cycle. gb_seq_o = seq_o delayed exactly PIPE_LAT cycles; PIPE_LAT=0 makes it combinationally equal to seq_o.
- blk_ready_o is combinational from state and counter only, never from blk_valid_i.
- rst_i mid-block: immediate return to the reset state; the partial block is discarded with no pulses.

Optional Feature:
TX_GBSEQ_STATS_EN
- Defined: idle_cnt_o and underrun_cnt_o are 32-bit counters.
  - Increment on idle_ins_o and underrun_o respectively.
  - Saturate at 32'hFFFF_FFFF; cleared by rst_i only.
- Undefined: both outputs are tied to 0 and no counter logic is built.

Test Plan:
- Reset, enable_i=1, valid held 1 with incrementing data -> seq_o runs 0..32,0,...; ready=0 only while the counter is at 32; data_o follows input 1 cycle later; head_o=2'b01 when driven so.
- enable_i=1, valid=0 always -> each block is data_o=32'h1E then 32'h0 with head_o=2'b10; idle_ins_o pulses on seq 0,2,...,30; 16 pulses per 33-cycle period.
- valid drops only at an odd seq (e.g. seq 5) -> data_o=0 at seq_o=5, underrun_o pulses once, next block resumes normally.
- enable_i deasserted at odd seq 7 -> block completes at seq 7, IDLE entered at seq 8 boundary, ready=0, seq_o returns to 0.
- PIPE_LAT=2 -> gb_seq_o equals seq_o from 2 cycles earlier across the 32->0 wrap.
- With TX_GBSEQ_STATS_EN, 100 idle blocks then rst_i mid-block -> idle_cnt_o=100 before reset, all counters and outputs 0 after reset.
